// File: rtl/odometer_meas_sequencer_pkg.sv
// Shared state encoding, default timing parameters and phase-counter helper
// for the odometer measurement-window sequencer.
package odometer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_ARM     = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } seq_state_e;

  localparam int unsigned DEF_PWR_SETTLE_CYC = 32'd4;
  localparam int unsigned DEF_ARM_CYC        = 32'd2;
  localparam int unsigned DEF_WDOG_W         = 32'd16;
  localparam int unsigned DEF_WDOG_LIMIT     = 32'h0000_FFF0;

  localparam int unsigned PHASE_W = 32'd4;

  // The phase counter counts down to zero, so an N-cycle phase loads N-1.
  function automatic logic [PHASE_W-1:0] phase_load(input int unsigned cyc);
    return PHASE_W'(cyc - 32'd1);
  endfunction

endpackage

// File: rtl/odometer_meas_sequencer_sync.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/odometer_meas_sequencer.sv
// Measurement-window sequencer: power settle, ROSC arming, then a detect wait
// guarded by a dead-zone flag and a cycle watchdog. Held in DONE/TIMEOUT until reset.
module odometer_meas_sequencer
  import odometer_seq_pkg::*;
#(
  parameter int unsigned PWR_SETTLE_CYC = DEF_PWR_SETTLE_CYC,
  parameter int unsigned ARM_CYC        = DEF_ARM_CYC,
  parameter int unsigned WDOG_W         = DEF_WDOG_W,
  parameter int unsigned WDOG_LIMIT     = DEF_WDOG_LIMIT
) (
  input  logic              AC_STRESS_CLK,
  input  logic              RESET_MEAS_STRESS,
  input  logic              MEAS_STRESS,
  input  logic              DETECT,
  input  logic              DEADZONE_COUNTER_MSB,
  input  logic              START_LATCHED,
  output logic              EN_PWR_REQ,
  output logic              EN_ROSC_REQ,
  output logic              SEQ_BUSY,
  output logic              MEAS_OK,
  output logic              MEAS_TIMEOUT,
  output logic [WDOG_W-1:0] WIN_CYC,
  output logic [2:0]        SEQ_STATE
);

  localparam logic [PHASE_W-1:0] PWR_LOAD  = phase_load(PWR_SETTLE_CYC);
  localparam logic [PHASE_W-1:0] ARM_LOAD  = phase_load(ARM_CYC);
  localparam logic [WDOG_W-1:0]  LIMIT     = WDOG_LIMIT[WDOG_W-1:0];

  logic ms_s;
  logic det_s;
  logic dz_s;
  logic det_q_r;
  logic det_rise_s;

  seq_state_e          state_r;
  seq_state_e          state_n_s;
  logic [PHASE_W-1:0]  phase_r;
  logic [PHASE_W-1:0]  phase_n_s;
  logic [WDOG_W-1:0]   win_n_s;
  logic                pwr_n_s;
  logic                rosc_n_s;
  logic                ok_n_s;
  logic                tmo_n_s;

  sync_2ff u_sync_ms (
    .clk (AC_STRESS_CLK),
    .rst (RESET_MEAS_STRESS),
    .d   (MEAS_STRESS),
    .q   (ms_s)
  );

  sync_2ff u_sync_det (
    .clk (AC_STRESS_CLK),
    .rst (RESET_MEAS_STRESS),
    .d   (DETECT),
    .q   (det_s)
  );

  sync_2ff u_sync_dz (
    .clk (AC_STRESS_CLK),
    .rst (RESET_MEAS_STRESS),
    .d   (DEADZONE_COUNTER_MSB),
    .q   (dz_s)
  );

  assign det_rise_s = det_s & ~det_q_r;

  // Delayed copy of the synchronised detect for edge detection.
  always_ff @(posedge AC_STRESS_CLK or posedge RESET_MEAS_STRESS) begin
    if (RESET_MEAS_STRESS) begin
      det_q_r <= 1'b0;
    end else begin
      det_q_r <= det_s;
    end
  end

  // Next-state and phase-counter decode.
  always_comb begin
    state_n_s = state_r;
    phase_n_s = phase_r;
    case (state_r)
      ST_IDLE: begin
        if (ms_s && START_LATCHED) begin
          state_n_s = ST_ARM;
          phase_n_s = ARM_LOAD;
        end else if (ms_s) begin
          state_n_s = ST_PWR_UP;
          phase_n_s = PWR_LOAD;
        end else begin
          phase_n_s = '0;
        end
      end
      ST_PWR_UP: begin
        if (!ms_s) begin
          state_n_s = ST_IDLE;
          phase_n_s = '0;
        end else if (phase_r == 4'd0) begin
          state_n_s = ST_ARM;
          phase_n_s = ARM_LOAD;
        end else begin
          phase_n_s = phase_r - 4'd1;
        end
      end
      // A detect edge seen while arming belongs to the previous window.
      ST_ARM: begin
        if (!ms_s) begin
          state_n_s = ST_IDLE;
          phase_n_s = '0;
        end else if (phase_r == 4'd0) begin
          state_n_s = ST_MEASURE;
        end else begin
          phase_n_s = phase_r - 4'd1;
        end
      end
      ST_MEASURE: begin
        if (!ms_s) begin
          state_n_s = ST_IDLE;
          phase_n_s = '0;
        end else if (det_rise_s) begin
          state_n_s = ST_DONE;
        end else if (dz_s) begin
          state_n_s = ST_TIMEOUT;
        end else if (WIN_CYC == LIMIT) begin
          state_n_s = ST_TIMEOUT;
        end else begin
          state_n_s = ST_MEASURE;
        end
      end
      ST_DONE:    state_n_s = ST_DONE;
      ST_TIMEOUT: state_n_s = ST_TIMEOUT;
      default: begin
        state_n_s = ST_IDLE;
        phase_n_s = '0;
      end
    endcase
  end

  // Window counter: counts every cycle spent in MEASURE, saturates, clears in IDLE.
  always_comb begin
    win_n_s = WIN_CYC;
    if (state_n_s == ST_MEASURE) begin
      if (WIN_CYC == LIMIT) begin
        win_n_s = WIN_CYC;
      end else begin
        win_n_s = WIN_CYC + WDOG_W'(1);
      end
    end else if (state_n_s == ST_IDLE) begin
      win_n_s = '0;
    end else begin
      win_n_s = WIN_CYC;
    end
  end

  // Moore output decode from the next state, registered alongside the state.
  always_comb begin
    pwr_n_s  = 1'b0;
    rosc_n_s = 1'b0;
    ok_n_s   = 1'b0;
    tmo_n_s  = 1'b0;
    case (state_n_s)
      ST_IDLE: begin
        pwr_n_s = 1'b0;
      end
      ST_PWR_UP: begin
        pwr_n_s = 1'b1;
      end
      ST_ARM, ST_MEASURE: begin
        pwr_n_s  = 1'b1;
        rosc_n_s = 1'b1;
      end
      ST_DONE: begin
        ok_n_s  = 1'b1;
        pwr_n_s = START_LATCHED;
      end
      ST_TIMEOUT: begin
        tmo_n_s = 1'b1;
        pwr_n_s = START_LATCHED;
      end
      default: begin
        pwr_n_s = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs.
  always_ff @(posedge AC_STRESS_CLK or posedge RESET_MEAS_STRESS) begin
    if (RESET_MEAS_STRESS) begin
      state_r      <= ST_IDLE;
      phase_r      <= '0;
      WIN_CYC      <= '0;
      EN_PWR_REQ   <= 1'b0;
      EN_ROSC_REQ  <= 1'b0;
      SEQ_BUSY     <= 1'b0;
      MEAS_OK      <= 1'b0;
      MEAS_TIMEOUT <= 1'b0;
      SEQ_STATE    <= 3'd0;
    end else begin
      state_r      <= state_n_s;
      phase_r      <= phase_n_s;
      WIN_CYC      <= win_n_s;
      EN_PWR_REQ   <= pwr_n_s;
      EN_ROSC_REQ  <= rosc_n_s;
      SEQ_BUSY     <= (state_n_s != ST_IDLE);
      MEAS_OK      <= ok_n_s;
      MEAS_TIMEOUT <= tmo_n_s;
      SEQ_STATE    <= state_n_s;
    end
  end

endmodule

// File: tb/tb_odometer_meas_sequencer.sv
// Directed bench for odometer_meas_sequencer with the watchdog limit set to 100.
module tb_odometer_meas_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ms  = 1'b0;
  logic        det = 1'b0;
  logic        dz  = 1'b0;
  logic        sl  = 1'b0;
  logic        en_pwr;
  logic        en_rosc;
  logic        busy;
  logic        ok;
  logic        tmo;
  logic [15:0] win;
  logic [2:0]  st;

  int n_vec = 0;
  int n_err = 0;
  logic sl_watch = 1'b0;
  logic saw_pwrup = 1'b0;

  odometer_meas_sequencer #(
    .PWR_SETTLE_CYC (32'd4),
    .ARM_CYC        (32'd2),
    .WDOG_W         (32'd16),
    .WDOG_LIMIT     (32'd100)
  ) dut (
    .AC_STRESS_CLK        (clk),
    .RESET_MEAS_STRESS    (rst),
    .MEAS_STRESS          (ms),
    .DETECT               (det),
    .DEADZONE_COUNTER_MSB (dz),
    .START_LATCHED        (sl),
    .EN_PWR_REQ           (en_pwr),
    .EN_ROSC_REQ          (en_rosc),
    .SEQ_BUSY             (busy),
    .MEAS_OK              (ok),
    .MEAS_TIMEOUT         (tmo),
    .WIN_CYC              (win),
    .SEQ_STATE            (st)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sl_watch && st == 3'd1) saw_pwrup <= 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    ms  = 1'b0;
    det = 1'b0;
    dz  = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    #2;
    chk("rst_state", st, 3'd0);
    chk("rst_pwr", en_pwr, 1'b0);
    chk("rst_rosc", en_rosc, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ok", ok, 1'b0);
    chk("rst_tmo", tmo, 1'b0);
    chk("rst_win", win, 16'd0);

    // Normal window, power settle visited, detect in MEASURE cycle 30.
    do_reset();
    sl = 1'b0;
    ms = 1'b1;
    tick(2);
    chk("t1_pwr_early", en_pwr, 1'b0);
    tick(1);
    chk("t1_pwr_rise", en_pwr, 1'b1);
    chk("t1_state_pwrup", st, 3'd1);
    chk("t1_rosc_low", en_rosc, 1'b0);
    chk("t1_busy", busy, 1'b1);
    tick(3);
    chk("t1_rosc_early", en_rosc, 1'b0);
    tick(1);
    chk("t1_rosc_rise", en_rosc, 1'b1);
    chk("t1_state_arm", st, 3'd2);
    tick(2);
    chk("t1_state_meas", st, 3'd3);
    chk("t1_win_entry", win, 16'd1);
    tick(29);
    det = 1'b1;
    tick(2);
    chk("t1_still_meas", st, 3'd3);
    tick(1);
    chk("t1_state_done", st, 3'd4);
    chk("t1_ok", ok, 1'b1);
    chk("t1_tmo", tmo, 1'b0);
    chk("t1_win", win, 16'd32);
    chk("t1_pwr_done", en_pwr, 1'b0);
    chk("t1_rosc_done", en_rosc, 1'b0);
    ms = 1'b0;
    tick(4);
    chk("t1_hold_done", st, 3'd4);
    chk("t1_hold_win", win, 16'd32);

    // Start already latched: PWR_UP skipped, power kept in DONE.
    do_reset();
    sl = 1'b1;
    sl_watch = 1'b1;
    ms = 1'b1;
    tick(3);
    chk("t2_pwr", en_pwr, 1'b1);
    chk("t2_rosc", en_rosc, 1'b1);
    chk("t2_state_arm", st, 3'd2);
    tick(2);
    chk("t2_state_meas", st, 3'd3);
    det = 1'b1;
    tick(3);
    chk("t2_state_done", st, 3'd4);
    chk("t2_ok", ok, 1'b1);
    chk("t2_pwr_done", en_pwr, 1'b1);
    chk("t2_rosc_done", en_rosc, 1'b0);
    chk("t2_win", win, 16'd3);
    sl_watch = 1'b0;
    chk("t2_no_pwrup", saw_pwrup, 1'b0);

    // Watchdog expiry at 100 MEASURE cycles.
    do_reset();
    sl = 1'b0;
    ms = 1'b1;
    tick(9);
    chk("t3_state_meas", st, 3'd3);
    tick(99);
    chk("t3_meas_99", st, 3'd3);
    chk("t3_win_99", win, 16'd100);
    tick(1);
    chk("t3_state_tmo", st, 3'd5);
    chk("t3_tmo", tmo, 1'b1);
    chk("t3_ok", ok, 1'b0);
    chk("t3_win", win, 16'd100);
    chk("t3_pwr", en_pwr, 1'b0);
    tick(5);
    chk("t3_win_frozen", win, 16'd100);
    ms = 1'b0;
    tick(4);
    chk("t3_hold_tmo", st, 3'd5);

    // Stale detect edge during ARM is ignored; a fresh edge later completes.
    do_reset();
    sl = 1'b1;
    ms = 1'b1;
    tick(1);
    det = 1'b1;
    tick(2);
    chk("t4_state_arm", st, 3'd2);
    tick(2);
    chk("t4_state_meas", st, 3'd3);
    tick(10);
    chk("t4_still_meas", st, 3'd3);
    chk("t4_no_ok", ok, 1'b0);
    det = 1'b0;
    tick(3);
    det = 1'b1;
    tick(3);
    chk("t4_done", st, 3'd4);
    chk("t4_ok", ok, 1'b1);

    // Dead-zone and detect synchronised together: detect wins.
    do_reset();
    sl = 1'b1;
    ms = 1'b1;
    tick(5);
    chk("t5_state_meas", st, 3'd3);
    dz  = 1'b1;
    det = 1'b1;
    tick(3);
    chk("t5_done", st, 3'd4);
    chk("t5_ok", ok, 1'b1);
    chk("t5_tmo", tmo, 1'b0);

    // Dead-zone alone aborts the window.
    do_reset();
    sl = 1'b1;
    ms = 1'b1;
    tick(5);
    dz = 1'b1;
    tick(3);
    chk("t5b_state_tmo", st, 3'd5);
    chk("t5b_tmo", tmo, 1'b1);
    chk("t5b_ok", ok, 1'b0);
    chk("t5b_pwr", en_pwr, 1'b1);
    chk("t5b_win", win, 16'd3);

    // Reset mid-MEASURE, MEAS_STRESS drop in ARM, then a clean window.
    do_reset();
    sl = 1'b0;
    ms = 1'b1;
    tick(12);
    chk("t6_state_meas", st, 3'd3);
    rst = 1'b1;
    #1;
    chk("t6_rst_pwr", en_pwr, 1'b0);
    chk("t6_rst_rosc", en_rosc, 1'b0);
    chk("t6_rst_state", st, 3'd0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_win", win, 16'd0);
    ms = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    ms = 1'b1;
    tick(7);
    chk("t6_state_arm", st, 3'd2);
    ms = 1'b0;
    tick(2);
    chk("t6_drop_meas", st, 3'd3);
    tick(1);
    chk("t6_drop_idle", st, 3'd0);
    chk("t6_drop_pwr", en_pwr, 1'b0);
    chk("t6_drop_rosc", en_rosc, 1'b0);
    chk("t6_drop_win", win, 16'd0);
    ms = 1'b1;
    tick(3);
    chk("t6_rec_pwrup", st, 3'd1);
    chk("t6_rec_pwr", en_pwr, 1'b1);
    tick(6);
    chk("t6_rec_meas", st, 3'd3);
    det = 1'b1;
    tick(3);
    chk("t6_rec_done", st, 3'd4);
    chk("t6_rec_ok", ok, 1'b1);
    chk("t6_rec_win", win, 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
